// File: rtl/types_pkg.sv
// Shared core types: word type, RAM word-index width and the response-source
// tag used by the unified-memory arbiter.
package types_pkg;

    localparam int ADDR_WIDTH = 10;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_I    = 2'd1,
        RESP_D    = 2'd2
    } resp_src_t;

    localparam int STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/arb_prio2.sv
// Two-input fixed-priority arbiter: the high-priority side wins conflicts
// until the low side has been denied STARVE_LIMIT cycles in a row.
module arb_prio2
    import types_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hi_req,
    input  logic       lo_req,
    output logic       hi_gnt,
    output logic       lo_gnt,
    output logic [3:0] starve_cnt
);

    logic force_lo;

    assign force_lo = (starve_cnt == 4'(STARVE_LIMIT));

    always_comb begin
        hi_gnt = 1'b0;
        lo_gnt = 1'b0;
        if (!reset) begin
            if (hi_req && !(lo_req && force_lo)) begin
                hi_gnt = 1'b1;
            end else if (lo_req) begin
                lo_gnt = 1'b1;
            end
        end
    end

    // Saturates at the limit so the override persists until the low side wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= 4'd0;
        end else if (lo_req && !lo_gnt) begin
            if (!force_lo) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end else begin
            starve_cnt <= 4'd0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous-read RAM between instruction fetch and
// load/store; read data comes back one cycle after grant, tagged by requester.
module mem_arbiter
    import types_pkg::*;
#(
    parameter int ADDR_WIDTH   = types_pkg::ADDR_WIDTH,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req,
    input  word_t                 i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output word_t                 i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [3:0]            d_be,
    input  word_t                 d_addr,
    input  word_t                 d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output word_t                 d_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output word_t                 mem_wdata,
    input  word_t                 mem_rdata
);

    resp_src_t  resp_state;
    logic [3:0] starve_cnt;
    logic       unused_bits;

    arb_prio2 #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk        (clk),
        .reset      (reset),
        .hi_req     (d_req),
        .lo_req     (i_req),
        .hi_gnt     (d_gnt),
        .lo_gnt     (i_gnt),
        .starve_cnt (starve_cnt)
    );

    // Byte offset and bits above the RAM size are dropped, so addresses wrap.
    assign mem_en    = i_gnt | d_gnt;
    assign mem_we    = d_gnt & d_we;
    assign mem_be    = (d_gnt && d_we) ? d_be : 4'hF;
    assign mem_addr  = i_gnt ? i_addr[ADDR_WIDTH+1:2] : d_addr[ADDR_WIDTH+1:2];
    assign mem_wdata = d_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_state <= RESP_NONE;
        end else if (i_gnt) begin
            resp_state <= RESP_I;
        end else if (d_gnt && !d_we) begin
            resp_state <= RESP_D;
        end else begin
            resp_state <= RESP_NONE;
        end
    end

    // A read granted just before reset must not report its data.
    assign i_rvalid = (resp_state == RESP_I) && !reset;
    assign d_rvalid = (resp_state == RESP_D) && !reset;
    assign i_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;

    assign unused_bits = ^{i_addr[31:ADDR_WIDTH+2], i_addr[1:0],
                           d_addr[31:ADDR_WIDTH+2], d_addr[1:0], starve_cnt};

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural byte-enabled RAM and a
// requester-stability checker.
module tb_mem_arbiter;
    import types_pkg::*;

    localparam int AW = 10;

    logic          clk;
    logic          reset;
    logic          i_req;
    logic [31:0]   i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [31:0]   i_rdata;
    logic          d_req;
    logic          d_we;
    logic [3:0]    d_be;
    logic [31:0]   d_addr;
    logic [31:0]   d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [31:0]   d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    logic [31:0]   ram [0:(1<<AW)-1];

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(
        .ADDR_WIDTH   (AW),
        .STARVE_LIMIT (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port synchronous-read RAM with byte-enabled writes.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("[TB] check %s did not match", tag);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Requesters must hold req and payload stable until granted.
    logic        i_pend_q = 1'b0;
    logic [31:0] i_addr_q;
    logic        d_pend_q = 1'b0;
    logic [69:0] d_pay_q;

    always @(negedge clk) begin
        if (i_pend_q) check_output("i_hold", {31'b0, (i_req === 1'b1) && (i_addr === i_addr_q)}, 32'd1);
        if (d_pend_q) check_output("d_hold", {31'b0, (d_req === 1'b1) && ({d_we, d_be, d_addr, d_wdata} ===
                                             {1'b0, d_pay_q[68:0]} || {d_we, d_be, d_addr, d_wdata} === d_pay_q[68:0])}, 32'd1);
        i_pend_q = i_req & ~i_gnt;
        i_addr_q = i_addr;
        d_pend_q = d_req & ~d_gnt;
        d_pay_q  = {1'b0, d_we, d_be, d_addr, d_wdata};
    end

    task automatic apply_stimulus(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                                  input logic [3:0] db, input logic [31:0] da, input logic [31:0] dd);
        i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_be = db; d_addr = da; d_wdata = dd;
    endtask

    logic        exp_i;
    logic        prev_i;
    logic [32:0] wide_addr;

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = {16'hA5A5, 16'(i)};
        ram[4] = 32'hDEADBEEF;
        ram[8] = 32'hAABBCCDD;
        mem_rdata = 32'h0;
        reset = 1'b1;
        apply_stimulus(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

        // Reset held two cycles with a pending fetch
        next_cycle(); #1;
        check_output("rst_i_gnt", {31'b0, i_gnt}, 32'd0);
        check_output("rst_mem_en", {31'b0, mem_en}, 32'd0);
        check_output("rst_i_rvalid", {31'b0, i_rvalid}, 32'd0);
        next_cycle(); #1;
        check_output("rst2_i_gnt", {31'b0, i_gnt}, 32'd0);
        reset = 1'b0;
        #1;
        check_output("post_rst_i_gnt", {31'b0, i_gnt}, 32'd1);
        check_output("fetch_mem_addr", 32'(mem_addr), 32'd4);
        check_output("fetch_mem_we", {31'b0, mem_we}, 32'd0);

        next_cycle();
        apply_stimulus(1'b0, 32'h10, 1'b1, 1'b1, 4'b0011, 32'h20, 32'h12345678);
        #1;
        check_output("fetch_i_rvalid", {31'b0, i_rvalid}, 32'd1);
        check_output("fetch_i_rdata", i_rdata, 32'hDEADBEEF);
        check_output("fetch_d_rvalid", {31'b0, d_rvalid}, 32'd0);

        // Partial write then read-back of the same word
        check_output("wr_d_gnt", {31'b0, d_gnt}, 32'd1);
        check_output("wr_mem_we", {31'b0, mem_we}, 32'd1);
        check_output("wr_mem_be", {28'b0, mem_be}, 32'h3);
        check_output("wr_mem_addr", 32'(mem_addr), 32'd8);
        check_output("wr_mem_wdata", mem_wdata, 32'h12345678);
        next_cycle();
        d_we = 1'b0;
        #1;
        check_output("wr_no_d_rvalid", {31'b0, d_rvalid}, 32'd0);
        check_output("wr_no_i_rvalid", {31'b0, i_rvalid}, 32'd0);
        check_output("rd_mem_be", {28'b0, mem_be}, 32'hF);
        check_output("rd_mem_we", {31'b0, mem_we}, 32'd0);
        next_cycle();
        d_req = 1'b0;
        #1;
        check_output("rd_d_rvalid", {31'b0, d_rvalid}, 32'd1);
        check_output("rd_d_rdata", d_rdata, 32'hAABB5678);
        check_output("idle_mem_en", {31'b0, mem_en}, 32'd0);

        // Continuous conflict: D,D,D,D,I repeating
        prev_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            if (k == 0) apply_stimulus(1'b1, 32'h10, 1'b1, 1'b0, 4'h0, 32'h24, 32'h0);
            #1;
            exp_i = (k % 5 == 4);
            check_output($sformatf("st%0d_i_gnt", k), {31'b0, i_gnt}, {31'b0, exp_i});
            check_output($sformatf("st%0d_d_gnt", k), {31'b0, d_gnt}, {31'b0, ~exp_i});
            check_output($sformatf("st%0d_cnt", k), {28'b0, dut.starve_cnt}, 32'(k % 5));
            if (k > 0) begin
                check_output($sformatf("st%0d_i_rvalid", k), {31'b0, i_rvalid}, {31'b0, prev_i});
                check_output($sformatf("st%0d_d_rvalid", k), {31'b0, d_rvalid}, {31'b0, ~prev_i});
                check_output($sformatf("st%0d_rdata", k), prev_i ? i_rdata : d_rdata,
                             prev_i ? 32'hDEADBEEF : 32'hA5A50009);
            end
            prev_i = exp_i;
        end
        next_cycle();
        i_req = 1'b0;
        #1;
        check_output("st_tail_d_gnt", {31'b0, d_gnt}, 32'd1);
        check_output("st_tail_i_rvalid", {31'b0, i_rvalid}, 32'd1);
        check_output("st_tail_i_rdata", i_rdata, 32'hDEADBEEF);
        check_output("st_tail_cnt", {28'b0, dut.starve_cnt}, 32'd0);
        next_cycle();
        d_req = 1'b0;
        #1;
        check_output("st_end_d_rvalid", {31'b0, d_rvalid}, 32'd1);
        check_output("st_end_d_rdata", d_rdata, 32'hA5A50009);

        // Address wrap and ignored byte offset
        next_cycle();
        wide_addr = 33'h1_0000_0004;
        i_req = 1'b1;
        i_addr = wide_addr[31:0];
        #1;
        check_output("wrap_i_mem_addr", 32'(mem_addr), 32'd1);
        next_cycle();
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h7, 32'h0);
        #1;
        check_output("lowbits_d_mem_addr", 32'(mem_addr), 32'd1);
        check_output("wrap_i_rdata", i_rvalid ? i_rdata : 32'hX, 32'hA5A50001);
        next_cycle();
        d_addr = 32'hFFFF_F00C;
        #1;
        check_output("wrap_d_mem_addr", 32'(mem_addr), 32'd3);
        check_output("lowbits_d_rdata", d_rvalid ? d_rdata : 32'hX, 32'hA5A50001);

        // Read in flight when reset arrives, with the counter non-zero
        next_cycle();
        apply_stimulus(1'b1, 32'h10, 1'b1, 1'b0, 4'h0, 32'h24, 32'h0);
        #1;
        check_output("rr_d_gnt", {31'b0, d_gnt}, 32'd1);
        next_cycle();
        reset = 1'b1;
        d_req = 1'b0;
        #1;
        check_output("rr_cnt_before", {28'b0, dut.starve_cnt}, 32'd1);
        check_output("rr_d_rvalid_n1", {31'b0, d_rvalid}, 32'd0);
        check_output("rr_i_gnt_rst", {31'b0, i_gnt}, 32'd0);
        check_output("rr_mem_en_rst", {31'b0, mem_en}, 32'd0);
        next_cycle();
        reset = 1'b0;
        #1;
        check_output("rr_d_rvalid_n2", {31'b0, d_rvalid}, 32'd0);
        check_output("rr_i_rvalid_n2", {31'b0, i_rvalid}, 32'd0);
        check_output("rr_cnt_after", {28'b0, dut.starve_cnt}, 32'd0);
        check_output("rr_i_gnt", {31'b0, i_gnt}, 32'd1);
        next_cycle();
        i_req = 1'b0;
        #1;
        check_output("rr_i_rvalid", {31'b0, i_rvalid}, 32'd1);
        check_output("rr_i_rdata", i_rdata, 32'hDEADBEEF);

        next_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port synchronous-read word RAM between the core's instruction-fetch port and its load/store port.
- Used by the unified-memory build of the core, in place of separate instr_mem/data_mem instances.
- Arbitration favours data accesses, with a starvation guard so fetch always progresses.
- Read data returns one cycle after grant and is tagged to the requester that was granted.

Parameters:
- ADDR_WIDTH, types_pkg::ADDR_WIDTH: word-index width of the RAM.
- STARVE_LIMIT, 4: consecutive denied fetch cycles after which the fetch port wins the next conflict; legal range 1..15.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- i_req  input  1  fetch request
- i_addr  input  32 (word_t)  fetch byte address
- i_gnt  output  1  fetch granted this cycle
- i_rvalid  output  1  fetch read data valid
- i_rdata  output  32  fetch read data
- d_req  input  1  data request
- d_we  input  1  data write (1) / read (0)
- d_be  input  4  byte enables for writes
- d_addr  input  32  data byte address
- d_wdata  input  32  write data
- d_gnt  output  1  data granted this cycle
- d_rvalid  output  1  data read data valid
- d_rdata  output  32  data read data
- mem_en  output  1  RAM access this cycle
- mem_we  output  1  RAM write
- mem_be  output  4  RAM byte enables
- mem_addr  output  ADDR_WIDTH  RAM word index
- mem_wdata  output  32  RAM write data
- mem_rdata  input  32  RAM read data, valid the cycle after a read access

Behaviour:
- Grant is combinational, same cycle as the request; at most one grant per cycle.
- Arbitration when both i_req and d_req are high:
  - d_gnt=1 unless starve_cnt == STARVE_LIMIT.
  - If starve_cnt == STARVE_LIMIT, i_gnt=1 instead.
- Single requester is granted unconditionally.
- Requester rule: req, addr, we, be and wdata must hold stable until gnt. The bench checks this with assertions; the block does not buffer.
- RAM drive:
  - mem_en = i_gnt | d_gnt.
  - mem_addr = granted addr[ADDR_WIDTH+1:2]. Bits [1:0] and bits above ADDR_WIDTH+1 are ignored, so addresses wrap modulo RAM size.
  - mem_we = d_gnt & d_we.
  - mem_be = d_be when writing, else 4'hF.
  - mem_wdata = d_wdata.
  - When idle, mem_en=0, mem_we=0 and the other mem_* outputs are don't-care.
- Response tracking: registered resp_state ∈ {RESP_NONE, RESP_I, RESP_D}.
  - Next state is RESP_I if i_gnt.
  - Next state is RESP_D if d_gnt & !d_we.
  - Otherwise next state is RESP_NONE. Writes produce no rvalid.
- Outputs from resp_state:
  - i_rvalid = (resp_state==RESP_I); d_rvalid = (resp_state==RESP_D).
  - i_rdata = d_rdata = mem_rdata, passed through combinationally; rvalid qualifies it.
- Latency: request granted in cycle N → rvalid and data in cycle N+1. Back-to-back grants give one access per cycle at full throughput.
- Starvation counter starve_cnt, 4 bits:
  - If i_req & !i_gnt, increment, saturating at STARVE_LIMIT.
  - Otherwise clear to 0.
- Reset: resp_state=RESP_NONE and starve_cnt=0, so i_rvalid=0 and d_rvalid=0 in the cycle after reset.
  - While reset is high, grants are forced to 0 and mem_en=0.
  - A read granted in the cycle reset is asserted yields no rvalid.
- Simultaneous fetch and data write under a starvation override: the write waits and the data port keeps d_req high.

Decomposition:
- types_pkg additions: typedef enum logic [1:0] resp_src_t {RESP_NONE, RESP_I, RESP_D}; localparam STARVE_LIMIT_DEFAULT = 4.
- word_t and ADDR_WIDTH are already defined in types_pkg.
- Natural sub-module: arb_prio2. It is a two-input fixed-priority arbiter with a force-low-priority input and contains the starvation counter. Response tracking and the mux stay in mem_arbiter.

Test Plan:
- Reset held 2 cycles with i_req=1 → i_gnt=0, mem_en=0, i_rvalid=0. After release: i_gnt=1, and i_rvalid=1 next cycle with i_rdata = RAM word at i_addr.
- i_req, i_addr=0x10, alone → mem_addr=4; next cycle i_rvalid=1, i_rdata=preloaded 0xDEADBEEF; d_rvalid=0.
- d_req, d_we=1, d_be=4'b0011, d_addr=0x20, d_wdata=0x12345678, then read 0x20 → mem_be=0011 on the write, no rvalid; the read returns lower half 0x5678 merged with the old upper half.
- Both requesting continuously (data reads), STARVE_LIMIT=4 → grant pattern D,D,D,D,I repeating. rvalid tags match the grant one cycle later and starve_cnt is 0 after each I.
- i_addr=0x1_0000_0004, ADDR_WIDTH=10 → mem_addr=1 (wrap); d_addr=0x7 → mem_addr=1 (low bits ignored).
- Read granted in cycle N with reset asserted in N+1 → no rvalid in N+1 or N+2; starve_cnt=0 after reset.
